// File: rtl/div_seq.sv
// Multicycle unsigned radix-2 restoring divider with start/busy/done handshake.
// One quotient bit per clock; q/f/dz are registered and update only when a result completes.
module div_seq #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] q,
    output logic [N-1:0] f,
    output logic         dz
);

    localparam int unsigned CW = $clog2(N + 1);

    typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

    state_e        state;
    logic [CW-1:0] cnt;
    logic [N:0]    rem;
    logic [N-1:0]  qs;
    logic [N-1:0]  dv;

    logic [N:0]    sh;
    logic [N+1:0]  trial;
    logic [N:0]    rem_nx;
    logic [N-1:0]  qs_nx;

    // One restoring step: shift the next dividend bit in and try to subtract the divisor.
    always_comb begin
        sh     = {rem[N-1:0], qs[N-1]};
        trial  = {1'b0, sh} - {2'b00, dv};
        rem_nx = sh;
        qs_nx  = {qs[N-2:0], 1'b0};
        if (!trial[N+1]) begin
            rem_nx = trial[N:0];
            qs_nx  = {qs[N-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= StIdle;
            cnt   <= '0;
            rem   <= '0;
            qs    <= '0;
            dv    <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            q     <= '0;
            f     <= '0;
            dz    <= 1'b0;
        end else begin
            done <= 1'b0;
            if ((state == StIdle || state == StFin) && start) begin
                qs    <= x;
                dv    <= y;
                rem   <= '0;
                cnt   <= CW'(N);
                busy  <= 1'b1;
                state <= StRun;
            end else begin
                unique case (state)
                    StIdle: state <= StIdle;
                    StRun: begin
                        // A zero divisor spends a single cycle here; qs still holds the dividend.
                        if (dv == '0) begin
                            state <= StFin;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            q     <= '1;
                            f     <= qs;
                            dz    <= 1'b1;
                        end else begin
                            rem <= rem_nx;
                            qs  <= qs_nx;
                            cnt <= cnt - CW'(1);
                            if (cnt == CW'(1)) begin
                                state <= StFin;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                q     <= qs_nx;
                                f     <= rem_nx[N-1:0];
                                dz    <= 1'b0;
                            end
                        end
                    end
                    StFin: state <= StIdle;
                    default: state <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Directed self-checking bench for div_seq (N=4): handshake timing, corner cases,
// divide-by-zero, ignored/back-to-back starts, mid-run reset and an exhaustive sweep.
module tb_div_seq;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] x;
    logic [3:0] y;
    logic       busy;
    logic       done;
    logic [3:0] q;
    logic [3:0] f;
    logic       dz;

    int checks   = 0;
    int failures = 0;

    div_seq #(.N(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .x    (x),
        .y    (y),
        .busy (busy),
        .done (done),
        .q    (q),
        .f    (f),
        .dz   (dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one divide; lat counts edges after the accepting edge until done is seen.
    task automatic run_div(input logic [3:0] xv, input logic [3:0] yv, output int lat);
        @(posedge clk); #1;
        x = xv; y = yv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        start = 1'b0; x = '0; y = '0; rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, q, f, dz} !== 11'd0) begin
            failures++;
            $display("FAIL reset_async: got busy=%b done=%b q=%0d f=%0d dz=%b, want all 0",
                     busy, done, q, f, dz);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_basic;
        @(posedge clk); #1;
        x = 4'd13; y = 4'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({busy, done} !== 2'b10) begin
                failures++;
                $display("FAIL basic_busy cycle %0d: got busy=%b done=%b, want 1 0", i, busy, done);
            end
            @(posedge clk); #1;
        end
        checks++;
        if ({busy, done, q, f, dz} !== {1'b0, 1'b1, 4'd4, 4'd1, 1'b0}) begin
            failures++;
            $display("FAIL basic_done: got busy=%b done=%b q=%0d f=%0d dz=%b, want 0 1 4 1 0",
                     busy, done, q, f, dz);
        end
        @(posedge clk); #1;
        checks++;
        if ({busy, done, q, f, dz} !== {1'b0, 1'b0, 4'd4, 4'd1, 1'b0}) begin
            failures++;
            $display("FAIL basic_hold: got busy=%b done=%b q=%0d f=%0d dz=%b, want 0 0 4 1 0",
                     busy, done, q, f, dz);
        end
    endtask

    task automatic test_vectors;
        logic [3:0] tx[4] = '{4'd15, 4'd2, 4'd0, 4'd15};
        logic [3:0] ty[4] = '{4'd1, 4'd9, 4'd5, 4'd15};
        logic [3:0] eq[4] = '{4'd15, 4'd0, 4'd0, 4'd1};
        logic [3:0] ef[4] = '{4'd0, 4'd2, 4'd0, 4'd0};
        int lat;
        for (int i = 0; i < 4; i++) begin
            run_div(tx[i], ty[i], lat);
            checks++;
            if (lat !== 4 || q !== eq[i] || f !== ef[i] || dz !== 1'b0) begin
                failures++;
                $display("FAIL vec %0d/%0d: got lat=%0d q=%0d f=%0d dz=%b, want 4 %0d %0d 0",
                         tx[i], ty[i], lat, q, f, dz, eq[i], ef[i]);
            end
        end
    endtask

    task automatic test_div_zero;
        int lat;
        run_div(4'd7, 4'd0, lat);
        checks++;
        if (lat !== 1 || busy !== 1'b0 || q !== 4'd15 || f !== 4'd7 || dz !== 1'b1) begin
            failures++;
            $display("FAIL div_zero: got lat=%0d busy=%b q=%0d f=%0d dz=%b, want 1 0 15 7 1",
                     lat, busy, q, f, dz);
        end
        run_div(4'd9, 4'd2, lat);
        checks++;
        if (lat !== 4 || q !== 4'd4 || f !== 4'd1 || dz !== 1'b0) begin
            failures++;
            $display("FAIL after_zero: got lat=%0d q=%0d f=%0d dz=%b, want 4 4 1 0",
                     lat, q, f, dz);
        end
    endtask

    task automatic test_start_ignored;
        int lat;
        int extra;
        @(posedge clk); #1;
        x = 4'd13; y = 4'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        x = 4'd6; y = 4'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 2;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat !== 4 || q !== 4'd4 || f !== 4'd1) begin
            failures++;
            $display("FAIL start_ignored: got lat=%0d q=%0d f=%0d, want 4 4 1", lat, q, f);
        end
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done || busy) extra++;
        end
        checks++;
        if (extra !== 0) begin
            failures++;
            $display("FAIL start_not_queued: got %0d busy/done cycles, want 0", extra);
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        @(posedge clk); #1;
        x = 4'd13; y = 4'd3; start = 1'b1;
        @(posedge clk); #1;
        x = 4'd14; y = 4'd5;
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat !== 4 || q !== 4'd4 || f !== 4'd1) begin
            failures++;
            $display("FAIL b2b_first: got lat=%0d q=%0d f=%0d, want 4 4 1", lat, q, f);
        end
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        checks++;
        if ({busy, done} !== 2'b10) begin
            failures++;
            $display("FAIL b2b_accept: got busy=%b done=%b, want 1 0", busy, done);
        end
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat !== 5 || q !== 4'd2 || f !== 4'd4 || dz !== 1'b0) begin
            failures++;
            $display("FAIL b2b_second: got gap=%0d q=%0d f=%0d dz=%b, want 5 2 4 0",
                     lat, q, f, dz);
        end
    endtask

    task automatic test_reset_mid;
        int lat;
        int seen;
        @(posedge clk); #1;
        x = 4'd13; y = 4'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, q, f, dz} !== 11'd0) begin
            failures++;
            $display("FAIL reset_mid: got busy=%b done=%b q=%0d f=%0d dz=%b, want all 0",
                     busy, done, q, f, dz);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done || busy) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL reset_no_done: got %0d busy/done cycles, want 0", seen);
        end
        run_div(4'd10, 4'd3, lat);
        checks++;
        if (lat !== 4 || q !== 4'd3 || f !== 4'd1 || dz !== 1'b0) begin
            failures++;
            $display("FAIL after_reset: got lat=%0d q=%0d f=%0d dz=%b, want 4 3 1 0",
                     lat, q, f, dz);
        end
    endtask

    task automatic test_exhaustive;
        int lat;
        int xi;
        int yi;
        bit ok;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                run_div(4'(a), 4'(b), lat);
                xi = int'(q) * b + int'(f);
                if (b == 0)
                    ok = (dz === 1'b1) && (q === 4'd15) && (f === 4'(a)) && (lat == 1);
                else
                    ok = (dz === 1'b0) && (xi == a) && (int'(f) < b) && (lat == 4);
                checks++;
                if (!ok) begin
                    failures++;
                    $display("FAIL exh %0d/%0d: got q=%0d f=%0d dz=%b lat=%0d, want q*y+f=%0d f<y",
                             a, b, q, f, dz, lat, a);
                end
            end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_vectors;
        test_div_zero;
        test_start_ignored;
        test_back_to_back;
        test_reset_mid;
        test_exhaustive;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
